bank_sequencer: RTL and testbench
=================================

# bank_sequencer

Sequencer that walks the day-3 digit ROM from address 0 to `NUM_ENTRIES-1` and presents each digit to the joltage scoring datapath as a valid/ready stream, tagging the last digit of each battery bank. It owns the ROM address counter and hides the registered ROM's one-cycle read latency behind a 2-entry buffer, so the scorer can stall without losing data. It sits between the ROM and the scorer inside `top`. It raises `done` once the final entry has been accepted, which replaces free-running counter-based completion detection.

## Interface
- `NUM_ENTRIES`, 200, number of ROM words to stream
- `ADDR_W`, 8, ROM address width; must satisfy `2**ADDR_W >= NUM_ENTRIES`
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a pass; honoured only in IDLE or DONE
- `rom_addr`  out  ADDR_W  registered ROM read address
- `rom_en`  out  1  ROM read enable; `rom_data` is valid exactly one cycle after an enabled read
- `rom_data`  in  8  bits[3:0] hold the digit; bit 7 marks the end of a bank; bits[6:4] are ignored
- `out_valid`  out  1  `out_digit` and `out_last` are valid
- `out_ready`  in  1  scorer accepts the current beat
- `out_digit`  out  4  digit value
- `out_last`  out  1  current digit is the last digit of its bank
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE; holds until the next `start` or `rst`
- `bank_count`  out  16  number of accepted beats with `out_last=1` in the current pass
- `digit_err`  out  1  sticky; set when an accepted digit is greater than 9

## Operation
- States:
  - IDLE: reset state.
  - RUN: issuing reads.
  - DRAIN: all reads issued, buffer not yet empty.
  - DONE: pass complete.
- IDLE/DONE + `start` → RUN. On entry: `rom_addr=0`, and `bank_count`, `digit_err` and the issue counter are cleared.
- RUN issues a read (`rom_en=1`) on a cycle only when buffer occupancy plus in-flight reads is less than 2. `rom_addr` increments after each issued read.
- RUN → DRAIN on the cycle the read of address `NUM_ENTRIES-1` is issued.
- DRAIN → DONE on the handshake (`out_valid && out_ready`) of the beat from address `NUM_ENTRIES-1`.
- ROM response is written into a 2-entry FIFO the cycle after issue. The FIFO head drives the `out_*` signals.
- Handshake rules:
  - Once `out_valid` is high, `out_digit` and `out_last` hold stable until accepted.
  - `out_valid` never depends combinationally on `out_ready`.
- `bank_count` increments by 1 on each accepted beat with `out_last=1`. It saturates at `0xFFFF`.
- `start` while `busy` is ignored.
- `start` in DONE restarts a full pass.
- `rst` in any state, including mid-pass, has the following effect on the next cycle:
  - state = IDLE
  - FIFO flushed; any in-flight ROM word is discarded
  - all outputs cleared
- Reset values of every output: `rom_addr=0`, `rom_en=0`, `out_valid=0`, `out_digit=0`, `out_last=0`, `busy=0`, `done=0`, `bank_count=0`, `digit_err=0`.

## Timing
- Edge E0 samples `start=1`. After E0: RUN, `rom_en=1`, `rom_addr=0`.
- After E1: ROM data for address 0 is available and `rom_addr=1`.
- After E2: `out_valid=1` carrying address 0. Start-to-first-beat latency is 2 cycles.
- With `out_ready` held high, throughput is 1 beat per cycle. A full pass takes `NUM_ENTRIES+2` cycles from `start` to `done`.
- Stall of N cycles: issue pauses once occupancy plus in-flight reaches 2. No beat is dropped or duplicated. Streaming resumes 1 beat/cycle on the first ready cycle.
- Simultaneous FIFO write and read on a full FIFO is legal: occupancy stays at 2.
- `done` rises the cycle after the final handshake.

## Structure
- Shared package `day3_pkg`:
  - ROM word field constants `DIGIT_LSB=0`, `DIGIT_W=4`, `LAST_BIT=7`
  - state enum `seq_state_t {IDLE, RUN, DRAIN, DONE}`
  - `MAX_DIGIT=9`
- One sub-module: `stream_fifo2`, a 2-entry valid/ready FIFO with synchronous reset and an occupancy output. Data width is 5: digit plus last flag.
- The ROM stays outside this block.

## Test plan
- Reset, 4-entry ROM `{3,4,5,9|last}`, `out_ready=1`, pulse `start`:
  - beats 3,4,5,9 on cycles 2–5
  - `out_last` only on 9
  - `done` after cycle 5
  - `bank_count=1`
- 200-entry ROM, 8 banks of 25, with `out_ready` toggling on a pseudo-random pattern:
  - all 200 beats arrive in address order, with no drops or duplicates
  - `bank_count=8` at `done`
- Hold `out_ready=0` for 10 cycles after the first beat:
  - `out_valid` stays high with digit stable
  - `rom_en` stops after occupancy plus in-flight reaches 2
  - streaming resumes with no gap
- Assert `rst` at beat 50 of 200, then pulse `start`:
  - all outputs are 0 the cycle after reset
  - the second pass starts at address 0 and completes with the correct count
- Pulse `start` mid-RUN:
  - ignored; the address sequence is unchanged
- ROM entry with value 12 accepted:
  - `digit_err=1`, stays set until the next `start`

Source files
------------

// File: rtl/day3_pkg.sv
// Shared definitions for the day-3 digit stream: ROM word fields and sequencer states.
package day3_pkg;
    localparam int DIGIT_LSB = 0;
    localparam int DIGIT_W   = 4;
    localparam int LAST_BIT  = 7;
    localparam int FIFO_W    = DIGIT_W + 1;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO with occupancy; write and read together on a full FIFO is legal.
module stream_fifo2 import day3_pkg::*; #(
    parameter int W = FIFO_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic [1:0]   occupancy
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign rd_valid  = (count != 2'd0);
    assign rd_data   = mem[rd_ptr];
    assign occupancy = count;
    assign pop       = rd_valid && rd_ready;
    assign push      = wr_valid && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bank_sequencer.sv
// Streams ROM digits 0..NUM_ENTRIES-1 to the scorer, hiding the ROM read latency behind a 2-entry FIFO.
//   state | meaning
//   IDLE  | reset state, waiting for start
//   RUN   | issuing ROM reads
//   DRAIN | all reads issued, FIFO not yet empty
//   DONE  | pass complete, waiting for start
module bank_sequencer import day3_pkg::*; #(
    parameter int NUM_ENTRIES = 200,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [7:0]        rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_digit,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       bank_count,
    output logic              digit_err
);
    seq_state_t        state;
    logic [ADDR_W-1:0] issue_left;
    logic              rd_pend;
    logic [FIFO_W-1:0] fifo_data;
    logic [1:0]        occ;
    logic [2:0]        slots;
    logic              accept;
    logic              last_accept;
    logic              unused_rom_bits;

    stream_fifo2 #(.W(FIFO_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (rd_pend),
        .wr_data   ({rom_data[LAST_BIT], rom_data[DIGIT_LSB +: DIGIT_W]}),
        .rd_valid  (out_valid),
        .rd_ready  (out_ready),
        .rd_data   (fifo_data),
        .occupancy (occ)
    );

    assign out_last        = fifo_data[DIGIT_W];
    assign out_digit       = fifo_data[DIGIT_W-1:0];
    assign unused_rom_bits = ^rom_data[LAST_BIT-1:DIGIT_LSB+DIGIT_W];
    assign accept          = out_valid && out_ready;

    // A beat accepted this cycle frees its slot, so the read issue can overlap the pop
    // and the stream keeps one beat per cycle with only two storage slots.
    assign slots  = {1'b0, occ} + {2'b0, rd_pend};
    assign rom_en = (state == RUN) && (slots < (3'd2 + {2'b0, accept}));

    assign last_accept = accept && (state == DRAIN) && !rd_pend && (occ == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= '0;
            issue_left <= '0;
            rd_pend    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bank_count <= '0;
            digit_err  <= 1'b0;
        end else begin
            rd_pend <= rom_en;
            if (accept && out_last && (bank_count != 16'hFFFF)) begin
                bank_count <= bank_count + 16'd1;
            end
            if (accept && (out_digit > MAX_DIGIT)) begin
                digit_err <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        rom_addr   <= '0;
                        issue_left <= ADDR_W'(NUM_ENTRIES - 1);
                        bank_count <= '0;
                        digit_err  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (rom_en) begin
                        rom_addr   <= rom_addr + 1'b1;
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bank_sequencer.sv
// Bench for bank_sequencer: a 4-entry instance checked cycle by cycle from a table, and a
// 200-entry instance checked by an in-order scoreboard under stalls, restarts and reset.
module tb_bank_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- 4-entry instance ----------------
    logic        s_rst = 1'b1, s_start = 1'b0, s_ready = 1'b1;
    logic [2:0]  s_addr;
    logic        s_rom_en, s_valid, s_last, s_busy, s_done, s_err;
    logic [7:0]  s_rom_data;
    logic [3:0]  s_digit;
    logic [15:0] s_bc;
    logic [7:0]  rom4 [0:7];

    bank_sequencer #(.NUM_ENTRIES(4), .ADDR_W(3)) dut_small (
        .clk(clk), .rst(s_rst), .start(s_start), .rom_addr(s_addr), .rom_en(s_rom_en),
        .rom_data(s_rom_data), .out_valid(s_valid), .out_ready(s_ready), .out_digit(s_digit),
        .out_last(s_last), .busy(s_busy), .done(s_done), .bank_count(s_bc), .digit_err(s_err)
    );

    always @(posedge clk) s_rom_data <= s_rom_en ? rom4[s_addr] : 8'hFC;

    // ---------------- 200-entry instance ----------------
    logic        b_rst = 1'b1, b_start = 1'b0, b_ready = 1'b1;
    logic [7:0]  b_addr;
    logic        b_rom_en, b_valid, b_last, b_busy, b_done, b_err;
    logic [7:0]  b_rom_data;
    logic [3:0]  b_digit;
    logic [15:0] b_bc;
    logic [7:0]  rom200 [0:255];

    bank_sequencer #(.NUM_ENTRIES(200), .ADDR_W(8)) dut (
        .clk(clk), .rst(b_rst), .start(b_start), .rom_addr(b_addr), .rom_en(b_rom_en),
        .rom_data(b_rom_data), .out_valid(b_valid), .out_ready(b_ready), .out_digit(b_digit),
        .out_last(b_last), .busy(b_busy), .done(b_done), .bank_count(b_bc), .digit_err(b_err)
    );

    always @(posedge clk) b_rom_data <= b_rom_en ? rom200[b_addr] : 8'hFC;

    int ready_mode = 1;  // 0 hold low, 1 hold high, 2 pseudo-random
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       b_ready = 1'b0;
            1:       b_ready = 1'b1;
            default: b_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard: a pass's expected beats are queued at start, popped on each handshake.
    logic [4:0] sb_q [$];
    logic       sb_on = 1'b0;
    int         beat_idx = 0;
    logic [4:0] exp_beat;

    always @(negedge clk) begin
        if (sb_on && b_valid && b_ready) begin
            if (sb_q.size() == 0) begin
                chk("extra_beat", 32'(beat_idx), 32'(200));
            end else begin
                exp_beat = sb_q.pop_front();
                chk($sformatf("beat%0d", beat_idx), 32'({b_last, b_digit}), 32'(exp_beat));
            end
            if (beat_idx == 77) chk("digit_err_before_bad", 32'(b_err), 32'(0));
            if (beat_idx == 78) chk("digit_err_after_bad", 32'(b_err), 32'(1));
            beat_idx++;
        end
    end

    task automatic arm_pass();
        sb_q.delete();
        for (int i = 0; i < 200; i++) sb_q.push_back({rom200[i][7], rom200[i][3:0]});
        beat_idx = 0;
        sb_on    = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!b_done && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 32'(b_done), 32'(1));
    endtask

    task automatic end_of_pass(input string tag);
        chk({tag, "_bank_count"}, 32'(b_bc), 32'(8));
        chk({tag, "_beats"}, 32'(beat_idx), 32'(200));
        chk({tag, "_queue_left"}, 32'(sb_q.size()), 32'(0));
        chk({tag, "_digit_err"}, 32'(b_err), 32'(1));
        chk({tag, "_busy"}, 32'(b_busy), 32'(0));
    endtask

    typedef struct {
        logic        rst, start, ready;
        logic        en;
        logic [2:0]  addr;
        logic        valid;
        logic [3:0]  digit;
        logic        last, busy, done;
        logic [15:0] bc;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rom4[0] = 8'h03; rom4[1] = 8'h04; rom4[2] = 8'h05; rom4[3] = 8'h89;
        for (int i = 4; i < 8; i++) rom4[i] = 8'hFC;
        for (int i = 0; i < 256; i++) begin
            if (i >= 200)      rom200[i] = 8'hFC;
            else if (i == 77)  rom200[i] = 8'h0C;
            else               rom200[i] = {(i % 25 == 24), 3'b000, 4'((i * 7 + 3) % 9 + 1)};
        end

        //            rst start rdy  en addr vld dig last busy done bc
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0};

        for (int i = 0; i < 11; i++) begin
            s_rst   = tbl[i].rst;
            s_start = tbl[i].start;
            s_ready = tbl[i].ready;
            tick();
            chk($sformatf("row%0d_rom_en", i), 32'(s_rom_en), 32'(tbl[i].en));
            chk($sformatf("row%0d_rom_addr", i), 32'(s_addr), 32'(tbl[i].addr));
            chk($sformatf("row%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
            chk($sformatf("row%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_done", i), 32'(s_done), 32'(tbl[i].done));
            chk($sformatf("row%0d_bank_count", i), 32'(s_bc), 32'(tbl[i].bc));
            if (tbl[i].valid || tbl[i].rst) begin
                chk($sformatf("row%0d_digit", i), 32'(s_digit), 32'(tbl[i].digit));
                chk($sformatf("row%0d_last", i), 32'(s_last), 32'(tbl[i].last));
            end
        end
        s_start = 1'b0;

        // Pass 1: stall after first beat, then random ready, with a stray start mid-RUN.
        #1;
        b_rst = 1'b0;
        ready_mode = 1;
        tick();
        #1;
        arm_pass();
        b_start = 1'b1;
        tick();
        chk("p1_first_rom_en", 32'(b_rom_en), 32'(1));
        chk("p1_first_rom_addr", 32'(b_addr), 32'(0));
        chk("p1_busy", 32'(b_busy), 32'(1));
        #1;
        b_start = 1'b0;
        tick();
        tick();
        chk("p1_first_valid", 32'(b_valid), 32'(1));
        ready_mode = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("stall%0d_valid", k), 32'(b_valid), 32'(1));
            chk($sformatf("stall%0d_digit", k), 32'(b_digit), 32'(rom200[0][3:0]));
            chk($sformatf("stall%0d_rom_en", k), 32'(b_rom_en), 32'(0));
            chk($sformatf("stall%0d_rom_addr", k), 32'(b_addr), 32'(2));
        end
        ready_mode = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("resume%0d_valid", k), 32'(b_valid), 32'(1));
        end
        ready_mode = 2;
        #1;
        b_start = 1'b1;
        tick();
        chk("midrun_start_busy", 32'(b_busy), 32'(1));
        #1;
        b_start = 1'b0;
        wait_done("p1_done");
        end_of_pass("p1");
        sb_on = 1'b0;

        // Pass 2: restart from DONE, reset at beat 50.
        #1;
        arm_pass();
        b_start = 1'b1;
        tick();
        chk("p2_digit_err_cleared", 32'(b_err), 32'(0));
        chk("p2_bank_count_cleared", 32'(b_bc), 32'(0));
        chk("p2_rom_addr", 32'(b_addr), 32'(0));
        chk("p2_done_cleared", 32'(b_done), 32'(0));
        #1;
        b_start = 1'b0;
        begin
            int n = 0;
            while (beat_idx < 50 && n < 2000) begin
                tick();
                n++;
            end
        end
        chk("p2_reach_beat50", 32'(beat_idx >= 50), 32'(1));
        #1;
        sb_on = 1'b0;
        b_rst = 1'b1;
        tick();
        chk("rst_rom_addr", 32'(b_addr), 32'(0));
        chk("rst_rom_en", 32'(b_rom_en), 32'(0));
        chk("rst_valid", 32'(b_valid), 32'(0));
        chk("rst_digit", 32'(b_digit), 32'(0));
        chk("rst_last", 32'(b_last), 32'(0));
        chk("rst_busy", 32'(b_busy), 32'(0));
        chk("rst_done", 32'(b_done), 32'(0));
        chk("rst_bank_count", 32'(b_bc), 32'(0));
        chk("rst_digit_err", 32'(b_err), 32'(0));
        #1;
        b_rst = 1'b0;
        tick();
        chk("idle_after_rst_valid", 32'(b_valid), 32'(0));

        // Pass 3: full pass after reset.
        #1;
        arm_pass();
        b_start = 1'b1;
        tick();
        chk("p3_rom_en", 32'(b_rom_en), 32'(1));
        chk("p3_rom_addr", 32'(b_addr), 32'(0));
        #1;
        b_start = 1'b0;
        wait_done("p3_done");
        end_of_pass("p3");
        tick();
        chk("p3_done_holds", 32'(b_done), 32'(1));
        chk("p3_digit_err_holds", 32'(b_err), 32'(1));
        sb_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
